// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit arbiter.
//   - Opcode constants for the bitwise logic unit.
//   - State type for the output register FSM.
package lu_pkg;

   localparam logic [2:0] OP_NAND  = 3'b000;
   localparam logic [2:0] OP_AND   = 3'b001;
   localparam logic [2:0] OP_OR    = 3'b010;
   localparam logic [2:0] OP_NOR   = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_XNOR  = 3'b101;
   localparam logic [2:0] OP_NOTA0 = 3'b110;
   localparam logic [2:0] OP_NOTA1 = 3'b111;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } lu_state_e;

endpackage

// File: rtl/lu_bitwise.sv
// Purely combinational WIDTH-bit bitwise logic unit.
// Ports:
//   sel [2:0]       opcode (see lu_pkg)
//   a, b [WIDTH-1:0] operands; b is ignored by the two NOT-a opcodes
//   y   [WIDTH-1:0] result
module lu_bitwise
   import lu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (sel)
         OP_NAND:  y = ~(a & b);
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NOR:   y = ~(a | b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_NOTA0: y = ~a;
         OP_NOTA1: y = ~a;
         default:  y = ~a;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between NREQ requesters.
// At most one operation is issued per cycle; the result is registered and
// returned on a single valid/ready response channel tagged with id and opcode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid [NREQ]         per-requester request valid
//   req_sel   [3*NREQ]       opcode of requester i at [3i+2:3i]
//   req_a/b   [WIDTH*NREQ]   operands of requester i at [WIDTH*i +: WIDTH]
//   req_ready [NREQ]         one-hot grant
//   resp_valid/resp_ready    response handshake
//   resp_data [WIDTH]        result
//   resp_id   [IDW]          requester that was served
//   resp_op   [3]            opcode that produced resp_data
module logic_unit_arbiter
   import lu_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [3*NREQ-1:0]     req_sel,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WIDTH-1:0]      resp_data,
   output logic [IDW-1:0]        resp_id,
   output logic [2:0]            resp_op
);

   if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
      $error("logic_unit_arbiter: NREQ must be in 2..8");
   end

   lu_state_e        state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [2:0]       op_q, op_d;
   logic [IDW-1:0]   ptr_q, ptr_d;

   logic             issue_ok;
   logic             found;
   logic             grant;
   logic [IDW-1:0]   gnt_idx;
   logic [2:0]       sel_g;
   logic [WIDTH-1:0] a_g, b_g, y_g;

   // Grant scan and operand mux. The scan walks offsets k = 0..NREQ-1 from
   // ptr; the modulo keeps wrap-around correct for non-power-of-two NREQ.
   always_comb begin
      issue_ok = (state_q == ST_EMPTY) || resp_ready;
      found    = 1'b0;
      gnt_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!found && req_valid[j] && (j == ((int'(ptr_q) + k) % NREQ))) begin
               found   = 1'b1;
               gnt_idx = IDW'(j);
            end
         end
      end
      grant     = issue_ok && !rst && found;
      req_ready = '0;
      sel_g     = '0;
      a_g       = '0;
      b_g       = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (int'(gnt_idx) == j) begin
            sel_g = req_sel[3*j +: 3];
            a_g   = req_a[WIDTH*j +: WIDTH];
            b_g   = req_b[WIDTH*j +: WIDTH];
            if (grant) req_ready[j] = 1'b1;
         end
      end
   end

   lu_bitwise #(.WIDTH(WIDTH)) u_bitwise (
      .sel (sel_g),
      .a   (a_g),
      .b   (b_g),
      .y   (y_g)
   );

   // Next state: a grant always (re)loads the register, so a simultaneous
   // drain and grant keeps FULL with no bubble.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      op_d    = op_q;
      ptr_d   = ptr_q;
      if (grant) begin
         state_d = ST_FULL;
         data_d  = y_g;
         id_d    = gnt_idx;
         op_d    = sel_g;
         ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end else if (resp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         op_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         op_q    <= op_d;
         ptr_q   <= ptr_d;
      end
   end

   assign resp_valid = (state_q == ST_FULL);
   assign resp_data  = data_q;
   assign resp_id    = id_q;
   assign resp_op    = op_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter (NREQ=4, WIDTH=4).
module tb_logic_unit_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [3*NREQ-1:0]     req_sel;
   logic [WIDTH*NREQ-1:0] req_a;
   logic [WIDTH*NREQ-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [WIDTH-1:0]      resp_data;
   logic [IDW-1:0]        resp_id;
   logic [2:0]            resp_op;

   always #5 clk = ~clk;

   logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_sel    (req_sel),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_op    (resp_op)
   );

   // Per-requester stimulus, packed onto the DUT buses.
   logic [NREQ-1:0]  tv;
   logic [2:0]       ts  [NREQ];
   logic [WIDTH-1:0] ta  [NREQ];
   logic [WIDTH-1:0] tb_ [NREQ];

   always_comb begin
      req_valid = tv;
      req_sel   = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_sel[3*i +: 3]     = ts[i];
         req_a[WIDTH*i +: WIDTH] = ta[i];
         req_b[WIDTH*i +: WIDTH] = tb_[i];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit               m_full = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   int               m_id = 0;
   int               m_op = 0;
   int               m_ptr = 0;
   int               last_gnt = -1;
   bit               cmp_en = 1'b0;

   function automatic logic [WIDTH-1:0] op_fn(input logic [2:0] s,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (s)
         3'd0:    return ~(a & b);
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return ~(a | b);
         3'd4:    return a ^ b;
         3'd5:    return ~(a ^ b);
         default: return ~a;
      endcase
   endfunction

   // Which requester must be granted now (-1 for none).
   function automatic int model_grant();
      if (rst || (m_full && !resp_ready)) return -1;
      for (int k = 0; k < NREQ; k++)
         if (tv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   // Previous-edge snapshot for the requester-stability rule.
   logic [NREQ-1:0]  pv = '0;
   logic [NREQ-1:0]  pg = '0;
   bit               prst = 1'b1;
   logic [2:0]       ps [NREQ];
   logic [WIDTH-1:0] pa [NREQ];
   logic [WIDTH-1:0] pb [NREQ];

   always @(posedge clk) begin
      int g;
      g = model_grant();
      for (int i = 0; i < NREQ; i++) begin
         if (!prst && pv[i] && !pg[i]) begin
            checks++;
            if (!tv[i] || ts[i] != ps[i] || ta[i] != pa[i] || tb_[i] != pb[i]) begin
               errors++;
               $display("FAIL req_rule: requester %0d dropped or changed before grant at %0t", i, $time);
            end
         end
         pv[i] = tv[i];
         pg[i] = (g == i);
         ps[i] = ts[i];
         pa[i] = ta[i];
         pb[i] = tb_[i];
      end
      prst = rst;
      last_gnt = g;
      if (rst) begin
         m_full = 1'b0; m_data = '0; m_id = 0; m_op = 0; m_ptr = 0;
      end else if (g >= 0) begin
         m_full = 1'b1;
         m_data = op_fn(ts[g], ta[g], tb_[g]);
         m_id   = g;
         m_op   = int'(ts[g]);
         m_ptr  = (g + 1) % NREQ;
      end else if (resp_ready) begin
         m_full = 1'b0;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      int g;
      logic [NREQ-1:0] e;
      if (cmp_en) begin
         g = model_grant();
         e = '0;
         if (g >= 0) e[g] = 1'b1;
         chk("cmp_req_ready", int'(req_ready), int'(e));
         chk("cmp_resp_valid", int'(resp_valid), int'(m_full));
         if (m_full) begin
            chk("cmp_resp_data", int'(resp_data), int'(m_data));
            chk("cmp_resp_id", int'(resp_id), m_id);
            chk("cmp_resp_op", int'(resp_op), m_op);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic half();
      @(negedge clk);
   endtask

   task automatic step(input bit drop);
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      if (drop && last_gnt >= 0) tv[last_gnt] = 1'b0;
   endtask

   logic [WIDTH-1:0] sweep_exp [8];
   int               fair_id   [10];
   bit               fair_drop [10];

   initial begin
      sweep_exp = '{4'b0111, 4'b1000, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b0011};
      fair_id   = '{0, 1, 2, 3, 0, 1, 3, 1, 3, 1};
      fair_drop = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
      rst = 1'b1;
      resp_ready = 1'b1;
      tv = '1;
      for (int i = 0; i < NREQ; i++) begin
         ts[i] = 3'd0; ta[i] = '0; tb_[i] = '0;
      end

      // 1. Reset with all requesters valid.
      half(); chk("rst_ready0", int'(req_ready), 0);
      step(0);
      half(); chk("rst_ready1", int'(req_ready), 0);
      chk("rst_valid", int'(resp_valid), 0);
      chk("rst_id", int'(resp_id), 0);
      step(0);
      rst = 1'b0;
      half(); chk("rst_first_grant", int'(req_ready), 4'b0001);
      step(1);
      for (int k = 0; k < 3; k++) begin half(); step(1); end
      half(); chk("rst_last_id", int'(resp_id), 3);
      step(0);

      // 2. Single request from requester 2.
      tv[2] = 1'b1; ts[2] = 3'b001; ta[2] = 4'b1100; tb_[2] = 4'b1010;
      half(); chk("single_ready", int'(req_ready), 4'b0100);
      step(1);
      half();
      chk("single_valid", int'(resp_valid), 1);
      chk("single_data", int'(resp_data), 4'b1000);
      chk("single_id", int'(resp_id), 2);
      chk("single_op", int'(resp_op), 3'b001);
      step(0);

      // 3. Opcode sweep on requester 0.
      ta[0] = 4'b1100; tb_[0] = 4'b1010;
      for (int s = 0; s < 8; s++) begin
         tv[0] = 1'b1; ts[0] = 3'(s);
         half();
         if (s > 0) chk("sweep_data", int'(resp_data), int'(sweep_exp[s-1]));
         step(1);
      end
      half();
      chk("sweep_data_last", int'(resp_data), int'(sweep_exp[7]));
      chk("sweep_op_last", int'(resp_op), 7);
      step(0);

      // 4. Fairness. Requester 3 first to bring the pointer to 0.
      for (int i = 0; i < NREQ; i++) begin ts[i] = 3'b100; tb_[i] = 4'b1010; end
      ta[0] = 4'b0001; ta[1] = 4'b1100; ta[2] = 4'b0011; ta[3] = 4'b1111;
      tv = 4'b1000;
      half(); chk("fair_pre_ready", int'(req_ready), 4'b1000);
      step(1);
      for (int k = 0; k < 10; k++) begin
         if (k == 0) tv = 4'b1111;
         if (k == 6) tv = 4'b1010;
         half();
         chk("fair_ready", int'(req_ready), 1 << fair_id[k]);
         chk("fair_valid", int'(resp_valid), 1);
         chk("fair_id", int'(resp_id), (k == 0) ? 3 : fair_id[k-1]);
         step(fair_drop[k]);
      end

      // 5. Backpressure on a FULL result (id 1, data 0110).
      resp_ready = 1'b0;
      tv[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         half();
         chk("bp_ready", int'(req_ready), 0);
         chk("bp_valid", int'(resp_valid), 1);
         chk("bp_data", int'(resp_data), 4'b0110);
         chk("bp_id", int'(resp_id), 1);
         step(1);
      end
      resp_ready = 1'b1;
      half(); chk("bp_release_ready", int'(req_ready), 4'b0100);
      step(1);
      half();
      chk("bp_reload_valid", int'(resp_valid), 1);
      chk("bp_reload_id", int'(resp_id), 2);
      chk("bp_reload_data", int'(resp_data), 4'b1001);
      step(0);

      // 6. Reset while FULL and stalled.
      ts[1] = 3'b000; ta[1] = 4'b0101; tb_[1] = 4'b0110;
      tv[1] = 1'b1; resp_ready = 1'b0;
      half(); chk("mid_ready", int'(req_ready), 4'b0010);
      step(1);
      half();
      chk("mid_full_data", int'(resp_data), 4'b1011);
      chk("mid_full_id", int'(resp_id), 1);
      step(0);
      rst = 1'b1; resp_ready = 1'b1; tv[0] = 1'b1; tv[3] = 1'b1;
      half(); chk("mid_rst_ready", int'(req_ready), 0);
      step(0);
      rst = 1'b0;
      half();
      chk("mid_after_valid", int'(resp_valid), 0);
      chk("mid_after_grant", int'(req_ready), 4'b0001);
      step(1);
      half();
      chk("mid_next_id", int'(resp_id), 0);
      chk("mid_next_ready", int'(req_ready), 4'b1000);
      step(1);
      half(); chk("mid_final_id", int'(resp_id), 3);
      step(0);
      for (int k = 0; k < 3; k++) begin half(); step(0); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
